// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit ahead of the single-cycle RV32I core.
// Requests pc from imem (valid/ready), waits for the response, holds it as ist.
// Ports: clk, reset (sync, active-high), pc, flush,
//   mem_req_valid/ready/addr, mem_resp_valid/data,
//   ist, ist_valid, ist_ready, fetch_err (00 ok, 01 misaligned, 10 timeout).
module ifu_fetch #(
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] pc,
  input  logic              flush,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [DATA_W-1:0] mem_resp_data,
  output logic [DATA_W-1:0] ist,
  output logic              ist_valid,
  input  logic              ist_ready,
  output logic [1:0]        fetch_err
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, REQ, WAIT, HOLD, ERR
  } state_t;

  state_t            state, state_n;
  logic [ADDR_W-1:0] addr_q, addr_n;
  logic [DATA_W-1:0] ist_n;
  logic              ist_valid_n;
  logic [1:0]        err_n;
  logic [CW-1:0]     cnt, cnt_n, cnt_inc;
  logic              drop, drop_n;
  logic              misaligned;

  assign misaligned = (pc[1:0] != 2'b00);
  // Saturating increment: the counter never wraps.
  assign cnt_inc = (cnt == TMAX) ? cnt : cnt + CW'(1);

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr_q    <= '0;
      ist       <= '0;
      ist_valid <= 1'b0;
      fetch_err <= 2'b00;
      cnt       <= '0;
      drop      <= 1'b0;
    end else begin
      state     <= state_n;
      addr_q    <= addr_n;
      ist       <= ist_n;
      ist_valid <= ist_valid_n;
      fetch_err <= err_n;
      cnt       <= cnt_n;
      drop      <= drop_n;
    end
  end

  always_comb begin
    state_n       = state;
    addr_n        = addr_q;
    ist_n         = ist;
    ist_valid_n   = ist_valid;
    err_n         = fetch_err;
    cnt_n         = cnt;
    drop_n        = drop;
    mem_req_valid = 1'b0;
    mem_req_addr  = addr_q;
    unique case (state)
      IDLE: state_n = REQ;
      REQ: begin
        // Address follows pc live, so a flush here loses nothing.
        mem_req_addr = pc;
        if (misaligned) begin
          state_n = ERR;
          err_n   = 2'b01;
        end else begin
          mem_req_valid = 1'b1;
          if (mem_req_ready) begin
            addr_n  = pc;
            cnt_n   = '0;
            // Accepted during a redirect: that response is stale.
            drop_n  = flush;
            state_n = WAIT;
          end
        end
      end
      WAIT: begin
        cnt_n = cnt_inc;
        if (mem_resp_valid) begin
          if (drop || flush) begin
            drop_n  = 1'b0;
            state_n = REQ;
          end else begin
            ist_n       = mem_resp_data;
            ist_valid_n = 1'b1;
            state_n     = HOLD;
          end
        end else begin
          if (flush) drop_n = 1'b1;
          if (cnt_inc == TMAX) begin
            drop_n  = 1'b0;
            err_n   = 2'b10;
            state_n = ERR;
          end
        end
      end
      HOLD: begin
        if (flush || ist_ready) begin
          ist_valid_n = 1'b0;
          state_n     = REQ;
        end
      end
      ERR: begin
        if (flush) begin
          err_n   = 2'b00;
          state_n = REQ;
        end
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// tb_ifu_fetch: scenario tasks plus a handshake scoreboard for ifu_fetch.
// dut uses the default TIMEOUT; dut_to uses TIMEOUT=4 for the timeout case.
module tb_ifu_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        mem_req_ready;
  logic        mem_resp_valid;
  logic [31:0] mem_resp_data;
  logic        ist_ready;

  logic        mem_req_valid, t_mem_req_valid;
  logic [31:0] mem_req_addr, t_mem_req_addr;
  logic [31:0] ist, t_ist;
  logic        ist_valid, t_ist_valid;
  logic [1:0]  fetch_err, t_fetch_err;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_addr[$];
  logic [31:0] exp_ist[$];

  always #5 clk = ~clk;

  ifu_fetch dut (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .ist(ist), .ist_valid(ist_valid),
    .ist_ready(ist_ready), .fetch_err(fetch_err)
  );

  ifu_fetch #(.TIMEOUT(4)) dut_to (
    .clk(clk), .reset(reset), .pc(pc), .flush(flush),
    .mem_req_valid(t_mem_req_valid), .mem_req_ready(mem_req_ready),
    .mem_req_addr(t_mem_req_addr), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data), .ist(t_ist), .ist_valid(t_ist_valid),
    .ist_ready(ist_ready), .fetch_err(t_fetch_err)
  );

  // Scoreboard: every request and every consumed instruction must be expected.
  always @(negedge clk) begin
    logic [31:0] e;
    if (!reset && mem_req_valid && mem_req_ready) begin
      n_checks++;
      if (exp_addr.size() == 0) begin
        n_fail++;
        $display("FAIL req_extra got addr=%h required no request", mem_req_addr);
      end else begin
        e = exp_addr.pop_front();
        if (mem_req_addr !== e) begin
          n_fail++;
          $display("FAIL req_addr got=%h required=%h", mem_req_addr, e);
        end
      end
    end
    if (!reset && ist_valid && ist_ready && !flush) begin
      n_checks++;
      if (exp_ist.size() == 0) begin
        n_fail++;
        $display("FAIL ist_extra got ist=%h required none", ist);
      end else begin
        e = exp_ist.pop_front();
        if (ist !== e) begin
          n_fail++;
          $display("FAIL ist_data got=%h required=%h", ist, e);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick;
    tick;
    reset = 1'b0;
    n_checks++;
    if (mem_req_valid !== 1'b0 || mem_req_addr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_req got v=%b a=%h required 0/0", mem_req_valid, mem_req_addr);
    end
    n_checks++;
    if (ist !== 32'h0 || ist_valid !== 1'b0 || fetch_err !== 2'b00) begin
      n_fail++;
      $display("FAIL rst_ist got %h/%b/%b required 0/0/00", ist, ist_valid, fetch_err);
    end
  endtask

  task automatic test_basic;
    pc = 32'h8000_0000;
    mem_req_ready = 1'b1;
    exp_addr.push_back(32'h8000_0000);
    tick;
    n_checks++;
    if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0000) begin
      n_fail++;
      $display("FAIL basic_req got %b/%h required 1/80000000", mem_req_valid, mem_req_addr);
    end
    tick;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0010_0093;
    n_checks++;
    if (ist_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_wait got iv=%b rv=%b required 0/0", ist_valid, mem_req_valid);
    end
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ist !== 32'h0010_0093 || ist_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_ist got %h/%b required 00100093/1", ist, ist_valid);
    end
    repeat (2) tick;
    n_checks++;
    if (ist !== 32'h0010_0093 || ist_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL basic_hold got %h/%b required 00100093/1", ist, ist_valid);
    end
    exp_ist.push_back(32'h0010_0093);
    ist_ready = 1'b1;
    tick;
    ist_ready = 1'b0;
    pc = 32'h8000_0004;
    n_checks++;
    if (ist_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL basic_consume got iv=%b required 0", ist_valid);
    end
  endtask

  task automatic test_back_to_back;
    exp_addr.push_back(32'h8000_0004);
    repeat (3) begin
      n_checks++;
      if (mem_req_valid !== 1'b1 || ist_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_stall got rv=%b iv=%b required 1/0", mem_req_valid, ist_valid);
      end
      tick;
    end
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    repeat (4) begin
      n_checks++;
      if (mem_req_valid !== 1'b0 || ist_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_gap got rv=%b iv=%b required 0/0", mem_req_valid, ist_valid);
      end
      tick;
    end
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0020_0113;
    exp_ist.push_back(32'h0020_0113);
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ist !== 32'h0020_0113 || ist_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_ist got %h/%b required 00200113/1", ist, ist_valid);
    end
    ist_ready = 1'b1;
    tick;
    ist_ready = 1'b0;
    pc = 32'h8000_0100;
  endtask

  task automatic test_flush_in_flight;
    exp_addr.push_back(32'h8000_0100);
    exp_addr.push_back(32'h8000_0100);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    flush = 1'b1;
    tick;
    flush = 1'b0;
    n_checks++;
    if (ist_valid !== 1'b0 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL fif_wait got iv=%b rv=%b required 0/0", ist_valid, mem_req_valid);
    end
    tick;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hDEAD_BEEF;
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ist_valid !== 1'b0 || mem_req_valid !== 1'b1 || mem_req_addr !== 32'h8000_0100) begin
      n_fail++;
      $display("FAIL fif_drop got iv=%b rv=%b a=%h required 0/1/80000100",
               ist_valid, mem_req_valid, mem_req_addr);
    end
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0000_0013;
    exp_ist.push_back(32'h0000_0013);
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ist !== 32'h0000_0013 || ist_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fif_ist got %h/%b required 00000013/1", ist, ist_valid);
    end
    ist_ready = 1'b1;
    tick;
    ist_ready = 1'b0;
    pc = 32'h8000_0200;
  endtask

  task automatic test_flush_collide;
    exp_addr.push_back(32'h8000_0200);
    exp_addr.push_back(32'h8000_0200);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'hCAFE_BABE;
    flush = 1'b1;
    tick;
    mem_resp_valid = 1'b0;
    flush = 1'b0;
    n_checks++;
    if (ist_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fcol_resp got iv=%b rv=%b required 0/1", ist_valid, mem_req_valid);
    end
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0030_0193;
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ist !== 32'h0030_0193 || ist_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fcol_ist got %h/%b required 00300193/1", ist, ist_valid);
    end
    flush = 1'b1;
    ist_ready = 1'b1;
    tick;
    flush = 1'b0;
    ist_ready = 1'b0;
    n_checks++;
    if (ist_valid !== 1'b0 || mem_req_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL fcol_hold got iv=%b rv=%b required 0/1", ist_valid, mem_req_valid);
    end
  endtask

  task automatic test_misaligned;
    pc = 32'h8000_0002;
    #1;
    n_checks++;
    if (mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_req got rv=%b required 0", mem_req_valid);
    end
    tick;
    mem_req_ready = 1'b1;
    n_checks++;
    if (fetch_err !== 2'b01 || mem_req_valid !== 1'b0 || ist_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_err got e=%b rv=%b iv=%b required 01/0/0",
               fetch_err, mem_req_valid, ist_valid);
    end
    repeat (3) tick;
    n_checks++;
    if (fetch_err !== 2'b01 || mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mis_hold got e=%b rv=%b required 01/0", fetch_err, mem_req_valid);
    end
    mem_req_ready = 1'b0;
    flush = 1'b1;
    pc = 32'h8000_0000;
    tick;
    flush = 1'b0;
    n_checks++;
    if (fetch_err !== 2'b00) begin
      n_fail++;
      $display("FAIL mis_clear got e=%b required 00", fetch_err);
    end
    exp_addr.push_back(32'h8000_0000);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h0040_0213;
    exp_ist.push_back(32'h0040_0213);
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (ist !== 32'h0040_0213 || ist_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL mis_fetch got %h/%b required 00400213/1", ist, ist_valid);
    end
    ist_ready = 1'b1;
    tick;
    ist_ready = 1'b0;
  endtask

  task automatic test_timeout;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    pc = 32'h8000_0000;
    exp_addr.push_back(32'h8000_0000);
    mem_req_ready = 1'b1;
    tick;
    tick;
    mem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick;
      n_checks++;
      if (t_fetch_err !== 2'b00) begin
        n_fail++;
        $display("FAIL to_early[%0d] got e=%b required 00", i, t_fetch_err);
      end
    end
    tick;
    n_checks++;
    if (t_fetch_err !== 2'b10 || t_mem_req_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_err got e=%b rv=%b required 10/0", t_fetch_err, t_mem_req_valid);
    end
    mem_resp_valid = 1'b1;
    mem_resp_data = 32'h1111_1111;
    tick;
    mem_resp_valid = 1'b0;
    n_checks++;
    if (t_ist_valid !== 1'b0 || t_ist !== 32'h0 || t_fetch_err !== 2'b10) begin
      n_fail++;
      $display("FAIL to_late got %h/%b/%b required 0/0/10", t_ist, t_ist_valid, t_fetch_err);
    end
    flush = 1'b1;
    tick;
    flush = 1'b0;
    exp_addr.push_back(32'h8000_0000);
    mem_req_ready = 1'b1;
    tick;
    mem_req_ready = 1'b0;
    tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    n_checks++;
    if (t_mem_req_valid !== 1'b0 || t_mem_req_addr !== 32'h0 || t_ist !== 32'h0 ||
        t_ist_valid !== 1'b0 || t_fetch_err !== 2'b00) begin
      n_fail++;
      $display("FAIL to_reset got %b/%h/%h/%b/%b required all zero", t_mem_req_valid,
               t_mem_req_addr, t_ist, t_ist_valid, t_fetch_err);
    end
    n_checks++;
    if (mem_req_addr !== 32'h0 || ist !== 32'h0 || ist_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL to_reset_main got a=%h ist=%h iv=%b required 0/0/0",
               mem_req_addr, ist, ist_valid);
    end
  endtask

  initial begin
    reset = 1'b1;
    pc = 32'h0;
    flush = 1'b0;
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0;
    mem_resp_data = 32'h0;
    ist_ready = 1'b0;
    test_reset;
    test_basic;
    test_back_to_back;
    test_flush_in_flight;
    test_flush_collide;
    test_misaligned;
    test_timeout;
    n_checks++;
    if (exp_addr.size() != 0 || exp_ist.size() != 0) begin
      n_fail++;
      $display("FAIL sb_drain got addr_left=%0d ist_left=%0d required 0/0",
               exp_addr.size(), exp_ist.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ifu_fetch.md
Name: ifu_fetch

Overview:
- Instruction fetch unit directly upstream of the single-cycle RV32I core.
- Takes the core's current pc, issues a valid/ready request to instruction memory and waits for a variable-latency response.
- Presents the returned word to the core as ist with a valid/ready handshake.
- Handles redirect flushes, misaligned pc and response timeout.

Parameters:
ADDR_W, 32, address width of pc and memory request
DATA_W, 32, instruction word width
TIMEOUT, 255, max cycles waiting for a response before a timeout error (must be ≥1)

Ports:
clk  input  1  clock
reset  input  1  synchronous active-high reset
pc  input  ADDR_W  current pc from core; stable until the core accepts an instruction
flush  input  1  redirect; discards any in-flight or held instruction
mem_req_valid  output  1  fetch request valid
mem_req_ready  input  1  memory accepts request
mem_req_addr  output  ADDR_W  fetch address
mem_resp_valid  input  1  response data valid (one-cycle pulse)
mem_resp_data  input  DATA_W  fetched word
ist  output  DATA_W  instruction to core
ist_valid  output  1  ist holds a valid instruction for pc
ist_ready  input  1  core consumes ist this cycle; pc updates on the same edge
fetch_err  output  2  00 none, 01 misaligned pc, 10 response timeout

Behaviour:
- Single clock domain.
- Reset is synchronous and active-high on clk/reset; it overrides everything, including mid-transaction.
- Reset values: state=IDLE, mem_req_valid=0, mem_req_addr=0, ist=0, ist_valid=0, fetch_err=00, timeout counter=0, drop flag=0.
- States: IDLE, REQ, WAIT, HOLD, ERR.
- IDLE: always go to REQ next cycle.
- REQ:
  - If pc[1:0]!=0: mem_req_valid=0; go to ERR with fetch_err=01.
  - Otherwise: mem_req_valid=1, mem_req_addr=pc (combinational from pc).
  - On mem_req_ready: latch the address, clear the counter, go to WAIT.
  - flush in REQ: stay in REQ; no request is lost, because the address tracks pc.
- WAIT:
  - mem_req_valid=0. Counter increments each cycle.
  - On mem_resp_valid with drop=0 and no flush: ist<=mem_resp_data, ist_valid<=1, go to HOLD.
  - On mem_resp_valid with drop=1, or with flush in the same cycle: discard the data, clear drop, go to REQ.
  - flush without a response: set drop, stay in WAIT.
  - Counter reaches TIMEOUT without a response: go to ERR with fetch_err=10. A response arriving later is ignored.
- HOLD:
  - ist_valid=1; ist stays stable.
  - flush: ist_valid<=0, go to REQ. flush takes priority over ist_ready.
  - ist_ready (no flush): ist_valid<=0, go to REQ. The new pc is visible in the REQ cycle.
- ERR:
  - ist_valid=0, mem_req_valid=0; fetch_err held.
  - flush: clear fetch_err, go to REQ. Only flush or reset leaves ERR.
- Latency: pc visible to ist_valid=1 is at least 2 cycles (REQ with ready high, then WAIT with resp_valid).
- ist_ready while ist_valid=0 is ignored.
- mem_resp_valid outside WAIT is ignored.
- Counter saturates; it never wraps.

Test Plan:
- Basic fetch: pc=0x80000000; mem_req_ready=1 in the first REQ cycle; resp 0x00100093 one cycle later -> mem_req_addr=0x80000000; ist=0x00100093, ist_valid=1 two cycles after leaving IDLE; ist holds until ist_ready.
- Back-to-back with backpressure: mem_req_ready low 3 cycles, response after 5 cycles, pc then 0x80000004 -> exactly one request per pc; ist_valid low during the gap; second ist correct.
- Flush in flight: flush in WAIT, then resp 0xDEADBEEF -> data discarded, ist_valid stays 0; a new request is issued for the current pc 0x80000100 and its response is delivered.
- Flush with simultaneous response, and flush+ist_ready in HOLD -> data discarded, state REQ, ist_valid=0 next cycle.
- Misaligned pc=0x80000002 -> no mem_req_valid; fetch_err=01; held until flush with pc=0x80000000, after which a normal fetch completes.
- Timeout with TIMEOUT=4: no response -> fetch_err=10 after 4 WAIT cycles; a late mem_resp_valid is ignored; reset mid-WAIT returns all outputs to reset values next cycle.
